// File: rtl/reg_pipe_if.sv
// reg_pipe_if: upstream/downstream handshake, flush and occupancy bundle for reg_pipe.
// The master modport is the pipeline's environment; the slave modport is the pipeline itself.
interface reg_pipe_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             flush;
  logic [CNT_W-1:0] occupancy;

  modport master (
    output in_data, in_valid, out_ready, flush,
    input  in_ready, out_data, out_valid, occupancy
  );

  modport slave (
    input  in_data, in_valid, out_ready, flush,
    output in_ready, out_data, out_valid, occupancy
  );
endinterface

// File: rtl/reg_pipe.sv
// reg_pipe: DEPTH-stage valid/ready register pipeline with bubble collapsing, flush and occupancy.
// Define REG_PIPE_DATA_RESET_EN to also load RESET_VALUE into the data registers on reset/flush.
module reg_pipe #(
  parameter int               WIDTH       = 8,
  parameter int               DEPTH       = 3,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input logic       clk,
  input logic       reset,
  reg_pipe_if.slave bus
);
  localparam int               CNT_W   = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
`ifdef REG_PIPE_DATA_RESET_EN
  localparam bit DATA_CLR = 1'b1;
`else
  localparam bit DATA_CLR = 1'b0;
`endif

  logic [WIDTH-1:0] data_p [DEPTH];
  logic [DEPTH-1:0] vld_p;
  logic [DEPTH-1:0] adv;
  logic [CNT_W-1:0] occ;
  logic             room;
  logic             clr;
  logic             in_xfer;
  logic             out_xfer;

  // A stage may load when any stage from it to the output is empty, or the output drains.
  always_comb begin
    adv  = '0;
    room = bus.out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      room   = room | ~vld_p[i];
      adv[i] = room;
    end
  end

  assign clr           = reset | bus.flush;
  assign bus.in_ready  = adv[0] & ~clr;
  assign in_xfer       = bus.in_valid & bus.in_ready;
  assign out_xfer      = vld_p[DEPTH-1] & bus.out_ready;
  assign bus.out_valid = vld_p[DEPTH-1];
  assign bus.out_data  = data_p[DEPTH-1];
  assign bus.occupancy = occ;

  // Control stage: valid bits and occupancy count
  always_ff @(posedge clk) begin
    if (clr) begin
      vld_p <= '0;
      occ   <= '0;
    end else begin
      if (adv[0]) vld_p[0] <= bus.in_valid;
      for (int i = 1; i < DEPTH; i++) begin
        if (adv[i]) vld_p[i] <= vld_p[i-1];
      end
      case ({in_xfer, out_xfer})
        2'b10:   occ <= occ + CNT_ONE;
        2'b01:   occ <= occ - CNT_ONE;
        default: occ <= occ;
      endcase
    end
  end

  // Data stage: a register only captures when a valid word moves into it
  always_ff @(posedge clk) begin
    if (DATA_CLR && clr) begin
      for (int i = 0; i < DEPTH; i++) data_p[i] <= RESET_VALUE;
    end else begin
      if (adv[0] && bus.in_valid) data_p[0] <= bus.in_data;
      for (int i = 1; i < DEPTH; i++) begin
        if (adv[i] && vld_p[i-1]) data_p[i] <= data_p[i-1];
      end
    end
  end

  a_hold_stalled: assert property (@(posedge clk)
    (!clr && bus.out_valid && !bus.out_ready) |=> (bus.out_valid && $stable(bus.out_data)));

endmodule

// File: tb/tb_reg_pipe.sv
// tb_reg_pipe: DEPTH=3 and DEPTH=1 pipelines driven in lockstep; table vectors plus random
// stimulus checked against a slot-position model of the pipeline.
module tb_reg_pipe;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  reg_pipe_if #(.WIDTH(8), .DEPTH(3)) if3 ();
  reg_pipe_if #(.WIDTH(8), .DEPTH(1)) if1 ();

  reg_pipe #(.WIDTH(8), .DEPTH(3), .RESET_VALUE(8'h5A)) u3 (.clk(clk), .reset(rst), .bus(if3));
  reg_pipe #(.WIDTH(8), .DEPTH(1), .RESET_VALUE(8'h5A)) u1 (.clk(clk), .reset(rst), .bus(if1));

  typedef struct {
    bit         rst;
    bit         fl;
    bit         iv;
    logic [7:0] d;
    bit         ordy;
    bit         chk;
    bit         e_ir;
    bit         e_ov;
    logic [7:0] e_od;
    int         e_occ;
  } vec_t;

  int checks = 0;
  int errors = 0;
  bit model_ok = 1'b0;

  // Model: per pipeline, an ordered list (oldest first) of words and the slot each occupies.
  int         dep [2] = '{3, 1};
  int         m_n [2];
  int         m_pos [2][4];
  logic [7:0] m_dat [2][4];

  vec_t tab3[$];
  vec_t tab1[$];

  function automatic vec_t mk(bit r, bit f, bit iv, logic [7:0] d, bit ordy,
                              bit chk, bit e_ir, bit e_ov, logic [7:0] e_od, int e_occ);
    vec_t v;
    v.rst = r; v.fl = f; v.iv = iv; v.d = d; v.ordy = ordy;
    v.chk = chk; v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_occ = e_occ;
    return v;
  endfunction

  task automatic check(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic bit model_ir(int m, vec_t v);
    return !v.rst && !v.fl && (v.ordy || m_n[m] < dep[m]);
  endfunction

  task automatic model_step(int m, vec_t v);
    int  limit;
    int  np;
    bit  irdy;
    irdy = model_ir(m, v);
    if (v.rst || v.fl) begin
      m_n[m] = 0;
      return;
    end
    // Every word moves one slot forward unless blocked by the word ahead; slot DEPTH means it left.
    limit = v.ordy ? dep[m] + 1 : dep[m];
    for (int j = 0; j < m_n[m]; j++) begin
      np = (m_pos[m][j] + 1 < limit - 1) ? m_pos[m][j] + 1 : limit - 1;
      m_pos[m][j] = np;
      limit = np;
    end
    if (m_n[m] > 0 && m_pos[m][0] == dep[m]) begin
      for (int j = 1; j < m_n[m]; j++) begin
        m_pos[m][j-1] = m_pos[m][j];
        m_dat[m][j-1] = m_dat[m][j];
      end
      m_n[m]--;
    end
    if (v.iv && irdy) begin
      m_pos[m][m_n[m]] = 0;
      m_dat[m][m_n[m]] = v.d;
      m_n[m]++;
    end
  endtask

  task automatic cycle(vec_t v, int tab, string tag);
    int  a_ir, a_ov, a_od, a_occ;
    bit  e_ov;
    rst = v.rst;
    if3.flush = v.fl; if3.in_valid = v.iv; if3.in_data = v.d; if3.out_ready = v.ordy;
    if1.flush = v.fl; if1.in_valid = v.iv; if1.in_data = v.d; if1.out_ready = v.ordy;
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      a_ir  = (m == 0) ? int'(if3.in_ready)  : int'(if1.in_ready);
      a_ov  = (m == 0) ? int'(if3.out_valid) : int'(if1.out_valid);
      a_od  = (m == 0) ? int'(if3.out_data)  : int'(if1.out_data);
      a_occ = (m == 0) ? int'(if3.occupancy) : int'(if1.occupancy);
      if (model_ok) begin
        e_ov = (m_n[m] > 0) && (m_pos[m][0] == dep[m] - 1);
        check($sformatf("%s.d%0d.in_ready", tag, dep[m]), a_ir, int'(model_ir(m, v)));
        check($sformatf("%s.d%0d.out_valid", tag, dep[m]), a_ov, int'(e_ov));
        check($sformatf("%s.d%0d.occupancy", tag, dep[m]), a_occ, m_n[m]);
        if (e_ov) check($sformatf("%s.d%0d.out_data", tag, dep[m]), a_od, int'(m_dat[m][0]));
      end
      if (tab == m && v.chk) begin
        check($sformatf("%s.tab.in_ready", tag), a_ir, int'(v.e_ir));
        check($sformatf("%s.tab.out_valid", tag), a_ov, int'(v.e_ov));
        check($sformatf("%s.tab.occupancy", tag), a_occ, v.e_occ);
        if (v.e_ov) check($sformatf("%s.tab.out_data", tag), a_od, int'(v.e_od));
      end
    end
    @(posedge clk);
    model_step(0, v);
    model_step(1, v);
    if (v.rst) model_ok = 1'b1;
    #1;
  endtask

  initial begin
    vec_t v;
    // DEPTH=3 table: rst fl iv d ordy | chk in_ready out_valid out_data occupancy (before the edge)
    tab3.push_back(mk(1,0,0,8'h00,1, 0,0,0,8'h00,0));
    tab3.push_back(mk(0,0,1,8'h11,1, 1,1,0,8'h00,0));
    tab3.push_back(mk(0,0,1,8'h22,1, 1,1,0,8'h00,1));
    tab3.push_back(mk(0,0,1,8'h33,1, 1,1,0,8'h00,2));
    tab3.push_back(mk(0,0,0,8'h00,1, 1,1,1,8'h11,3));
    tab3.push_back(mk(0,0,0,8'h00,1, 1,1,1,8'h22,2));
    tab3.push_back(mk(0,0,0,8'h00,1, 1,1,1,8'h33,1));
    tab3.push_back(mk(0,0,0,8'h00,1, 1,1,0,8'h00,0));
    tab3.push_back(mk(0,0,1,8'hA0,0, 1,1,0,8'h00,0));
    tab3.push_back(mk(0,0,1,8'hA1,0, 1,1,0,8'h00,1));
    tab3.push_back(mk(0,0,1,8'hA2,0, 1,1,0,8'h00,2));
    tab3.push_back(mk(0,0,1,8'hA3,0, 1,0,1,8'hA0,3));
    tab3.push_back(mk(0,0,1,8'hA3,1, 1,1,1,8'hA0,3));
    tab3.push_back(mk(0,0,0,8'h00,0, 1,0,1,8'hA1,3));
    tab3.push_back(mk(0,1,0,8'h00,0, 1,0,1,8'hA1,3));
    tab3.push_back(mk(0,0,0,8'h00,0, 1,1,0,8'h00,0));
    tab3.push_back(mk(0,0,1,8'h01,0, 1,1,0,8'h00,0));
    tab3.push_back(mk(0,0,0,8'h00,0, 1,1,0,8'h00,1));
    tab3.push_back(mk(0,0,1,8'h02,0, 1,1,0,8'h00,1));
    tab3.push_back(mk(0,0,0,8'h00,0, 1,1,1,8'h01,2));
    tab3.push_back(mk(0,0,0,8'h00,0, 1,1,1,8'h01,2));
    tab3.push_back(mk(0,1,1,8'h55,0, 1,0,1,8'h01,2));
    tab3.push_back(mk(0,0,0,8'h00,1, 1,1,0,8'h00,0));
    tab3.push_back(mk(0,0,0,8'h00,1, 1,1,0,8'h00,0));
    tab3.push_back(mk(0,0,0,8'h00,1, 1,1,0,8'h00,0));
    tab3.push_back(mk(0,0,1,8'hC1,0, 1,1,0,8'h00,0));
    tab3.push_back(mk(0,0,1,8'hC2,0, 1,1,0,8'h00,1));
    tab3.push_back(mk(0,0,1,8'hC3,0, 1,1,0,8'h00,2));
    tab3.push_back(mk(1,0,1,8'hC4,0, 1,0,1,8'hC1,3));
    tab3.push_back(mk(0,0,0,8'h00,0, 1,1,0,8'h00,0));

    // DEPTH=1 table: accept, stall, release with simultaneous in/out transfers
    tab1.push_back(mk(1,0,0,8'h00,1, 0,0,0,8'h00,0));
    tab1.push_back(mk(0,0,1,8'hB0,1, 1,1,0,8'h00,0));
    tab1.push_back(mk(0,0,1,8'hB1,0, 1,0,1,8'hB0,1));
    tab1.push_back(mk(0,0,1,8'hB1,0, 1,0,1,8'hB0,1));
    tab1.push_back(mk(0,0,1,8'hB1,1, 1,1,1,8'hB0,1));
    tab1.push_back(mk(0,0,1,8'hB2,1, 1,1,1,8'hB1,1));
    tab1.push_back(mk(0,0,0,8'h00,1, 1,1,1,8'hB2,1));
    tab1.push_back(mk(0,0,0,8'h00,0, 1,1,0,8'h00,0));
    tab1.push_back(mk(0,0,1,8'hB3,0, 1,1,0,8'h00,0));
    tab1.push_back(mk(0,0,0,8'h00,1, 1,1,1,8'hB3,1));
    tab1.push_back(mk(0,0,0,8'h00,1, 1,1,0,8'h00,0));

    for (int i = 0; i < tab3.size(); i++) cycle(tab3[i], 0, $sformatf("t3_%0d", i));

`ifdef REG_PIPE_DATA_RESET_EN
    check("reset_value.d3", int'(if3.out_data), 8'h5A);
    check("reset_value.d1", int'(if1.out_data), 8'h5A);
`endif

    for (int i = 0; i < tab1.size(); i++) cycle(tab1[i], 1, $sformatf("t1_%0d", i));

    // Random traffic with shifting downstream pressure, occasional flush and reset
    for (int i = 0; i < 3000; i++) begin
      v = mk(0,0,0,8'h00,0, 0,0,0,8'h00,0);
      v.rst  = ($urandom_range(0, 149) == 0);
      v.fl   = ($urandom_range(0, 59) == 0);
      v.iv   = ($urandom_range(0, 3) != 0);
      v.d    = 8'($urandom);
      v.ordy = (((i / 200) % 2) == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      cycle(v, -1, $sformatf("rnd_%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
